regfile_bypass_sb: RTL and testbench

Parametrised two-read/two-write general-purpose register file for the MIPS pipeline, with write-to-read bypass and a per-register busy scoreboard. It sits between decode (read and reserve) and writeback (two write ports). It replaces the single-write, opposite-edge-write register file: all state updates on the rising edge, and same-cycle write data reaches readers through the bypass. Decode uses the busy bits to detect RAW hazards and stall without a separate hazard table.

---
 rtl/regfile_bypass_sb.sv | 123 ++++++++++++
 tb/tb_regfile_bypass_sb.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_bypass_sb.sv
// Two-read/two-write register file with a write-to-read bypass and a per-register busy
// scoreboard. Decode reads and reserves registers; writeback drives the two write ports.
module regfile_bypass_sb #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter bit INIT_INDEX = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en0,
  input  logic              wr_en1,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_rd [DEPTH];
  logic [DEPTH-1:0]  busy_vec;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;

  genvar gi;

  // One storage word and busy bit per register; entry 0 is a constant zero that never goes busy.
  for (gi = 0; gi < DEPTH; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign mem_rd[gi]   = '0;
      assign busy_vec[gi] = 1'b0;
      assign busy_nxt[gi] = 1'b0;
    end else begin : g_word
      localparam logic [ADDR_W-1:0] IDX      = ADDR_W'(gi);
      localparam logic [DATA_W-1:0] INIT_VAL = INIT_INDEX ? DATA_W'(gi) : '0;

      logic [DATA_W-1:0] word_q, word_d;
      logic              busy_q, busy_d;
      logic              wr_hit0, wr_hit1;

      // Port 1 overrides port 0; a reservation beats the clear from a same-cycle write.
      always_comb begin
        wr_hit0 = wr_en0 && (wr_addr0 == IDX);
        wr_hit1 = wr_en1 && (wr_addr1 == IDX);
        word_d  = word_q;
        if (wr_hit0) word_d = wr_data0;
        if (wr_hit1) word_d = wr_data1;
        busy_d = busy_q;
        if (wr_hit0 || wr_hit1) busy_d = 1'b0;
        if (rsv_en && (rsv_addr == IDX)) busy_d = 1'b1;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          word_q <= INIT_VAL;
          busy_q <= 1'b0;
        end else begin
          word_q <= word_d;
          busy_q <= busy_d;
        end
      end

      assign mem_rd[gi]   = word_q;
      assign busy_vec[gi] = busy_q;
      assign busy_nxt[gi] = busy_d;
    end
  end

  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_val  [2];
  logic              rd_bsy  [2];

  assign rd_addr[0] = rd_addr1;
  assign rd_addr[1] = rd_addr2;

  // A reader hitting a same-cycle write sees the new value and not-busy together.
  for (gi = 0; gi < 2; gi++) begin : g_rd
    logic              hit0, hit1;
    logic [DATA_W-1:0] val;
    logic              bsy;

    always_comb begin
      hit0 = wr_en0 && (wr_addr0 == rd_addr[gi]) && (rd_addr[gi] != '0);
      hit1 = wr_en1 && (wr_addr1 == rd_addr[gi]) && (rd_addr[gi] != '0);
      val  = mem_rd[rd_addr[gi]];
      if (hit0) val = wr_data0;
      if (hit1) val = wr_data1;
      bsy = busy_vec[rd_addr[gi]] && !(hit0 || hit1);
    end

    assign rd_val[gi] = val;
    assign rd_bsy[gi] = bsy;
  end

  assign rd_data1 = rd_val[0];
  assign rd_data2 = rd_val[1];
  assign rd_busy1 = rd_bsy[0];
  assign rd_busy2 = rd_bsy[1];

  always_comb begin
    busy_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_nxt[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) busy_cnt_q <= '0;
    else     busy_cnt_q <= busy_cnt_d;
  end

  assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Bench for regfile_bypass_sb: directed test-plan steps then random traffic, all checked
// against an array-based reference model of the register file and scoreboard.
module tb_regfile_bypass_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr1, rd_addr2;
  logic        wr_en0, wr_en1;
  logic [4:0]  wr_addr0, wr_addr1;
  logic [31:0] wr_data0, wr_data1;
  logic        rsv_en;
  logic [4:0]  rsv_addr;

  logic [31:0] d1_rd_data1, d1_rd_data2, d0_rd_data1, d0_rd_data2;
  logic        d1_rd_busy1, d1_rd_busy2, d0_rd_busy1, d0_rd_busy2;
  logic [5:0]  d1_busy_cnt, d0_busy_cnt;

  int n_cmp = 0;
  int n_err = 0;
  string step_tag;

  always #5 clk = ~clk;

  regfile_bypass_sb #(.DATA_W(32), .ADDR_W(5), .INIT_INDEX(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(d1_rd_data1), .rd_data2(d1_rd_data2),
    .rd_busy1(d1_rd_busy1), .rd_busy2(d1_rd_busy2),
    .wr_en0(wr_en0), .wr_en1(wr_en1),
    .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_cnt(d1_busy_cnt)
  );

  regfile_bypass_sb #(.DATA_W(32), .ADDR_W(5), .INIT_INDEX(1'b0)) u_dut0 (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(d0_rd_data1), .rd_data2(d0_rd_data2),
    .rd_busy1(d0_rd_busy1), .rd_busy2(d0_rd_busy2),
    .wr_en0(wr_en0), .wr_en1(wr_en1),
    .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_cnt(d0_busy_cnt)
  );

  // Reference model: contents for both reset flavours plus one busy flag per register.
  logic [31:0] m_mem1 [32];
  logic [31:0] m_mem0 [32];
  bit          m_busy [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem1[i] = 32'(i);
      m_mem0[i] = 32'h0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic bit writes_now(input logic [4:0] a);
    return (a != 5'd0) && ((wr_en0 && wr_addr0 == a) || (wr_en1 && wr_addr1 == a));
  endfunction

  function automatic logic [31:0] exp_rd(input bit init_idx, input logic [4:0] a);
    logic [31:0] v;
    if (a == 5'd0) return 32'h0;
    v = init_idx ? m_mem1[a] : m_mem0[a];
    if (wr_en0 && wr_addr0 == a) v = wr_data0;
    if (wr_en1 && wr_addr1 == a) v = wr_data1;
    return v;
  endfunction

  function automatic logic [31:0] exp_busy(input logic [4:0] a);
    return {31'd0, (a != 5'd0) && m_busy[a] && !writes_now(a)};
  endfunction

  function automatic logic [31:0] exp_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return 32'(c);
  endfunction

  task automatic m_edge();
    if (rst) begin
      m_reset();
    end else begin
      if (wr_en0 && wr_addr0 != 5'd0) begin
        m_mem1[wr_addr0] = wr_data0; m_mem0[wr_addr0] = wr_data0; m_busy[wr_addr0] = 1'b0;
      end
      if (wr_en1 && wr_addr1 != 5'd0) begin
        m_mem1[wr_addr1] = wr_data1; m_mem0[wr_addr1] = wr_data1; m_busy[wr_addr1] = 1'b0;
      end
      if (rsv_en && rsv_addr != 5'd0) m_busy[rsv_addr] = 1'b1;
    end
  endtask

  task automatic idle();
    wr_en0 = 1'b0; wr_en1 = 1'b0; rsv_en = 1'b0; rst = 1'b0;
    wr_addr0 = 5'd0; wr_addr1 = 5'd0; wr_data0 = 32'h0; wr_data1 = 32'h0; rsv_addr = 5'd0;
  endtask

  // Inputs are set after a falling edge; check, then advance one rising edge.
  task automatic cycle();
    #1;
    $display("step %s: rst=%0b rd=%0d/%0d wr0=%0b@%0d wr1=%0b@%0d rsv=%0b@%0d -> %h %h busy=%0b%0b cnt=%0d",
             step_tag, rst, rd_addr1, rd_addr2, wr_en0, wr_addr0, wr_en1, wr_addr1,
             rsv_en, rsv_addr, d1_rd_data1, d1_rd_data2, d1_rd_busy1, d1_rd_busy2, d1_busy_cnt);
    chk({step_tag, "/rd_data1"}, d1_rd_data1, exp_rd(1'b1, rd_addr1));
    chk({step_tag, "/rd_data2"}, d1_rd_data2, exp_rd(1'b1, rd_addr2));
    chk({step_tag, "/rd_busy1"}, 32'(d1_rd_busy1), exp_busy(rd_addr1));
    chk({step_tag, "/rd_busy2"}, 32'(d1_rd_busy2), exp_busy(rd_addr2));
    chk({step_tag, "/busy_cnt"}, 32'(d1_busy_cnt), exp_cnt());
    chk({step_tag, "/z_rd_data1"}, d0_rd_data1, exp_rd(1'b0, rd_addr1));
    chk({step_tag, "/z_rd_data2"}, d0_rd_data2, exp_rd(1'b0, rd_addr2));
    chk({step_tag, "/z_busy_cnt"}, 32'(d0_busy_cnt), exp_cnt());
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst = 1'b1; rd_addr1 = 5'd7; rd_addr2 = 5'd0;
    @(posedge clk);
    m_reset();
    @(negedge clk);
    rst = 1'b0;

    step_tag = "reset";
    #1;
    chk("reset/rd1_is_7", d1_rd_data1, 32'd7);
    chk("reset/init0_rd1_is_0", d0_rd_data1, 32'd0);
    chk("reset/busy_cnt_0", 32'(d1_busy_cnt), 32'd0);
    cycle();

    step_tag = "bypass_wr5";
    wr_en0 = 1'b1; wr_addr0 = 5'd5; wr_data0 = 32'hA5A5_0000; rd_addr1 = 5'd5;
    #1 chk("bypass_wr5/same_cycle", d1_rd_data1, 32'hA5A5_0000);
    cycle();
    step_tag = "array_rd5";
    idle(); rd_addr1 = 5'd5;
    cycle();
    step_tag = "wr_addr0";
    wr_en0 = 1'b1; wr_addr0 = 5'd0; wr_data0 = 32'hFFFF_FFFF; rd_addr1 = 5'd0;
    cycle();
    idle();
    cycle();

    step_tag = "dual_wr9";
    wr_en0 = 1'b1; wr_addr0 = 5'd9; wr_data0 = 32'h1111;
    wr_en1 = 1'b1; wr_addr1 = 5'd9; wr_data1 = 32'h2222; rd_addr1 = 5'd9;
    #1 chk("dual_wr9/port1_wins", d1_rd_data1, 32'h2222);
    cycle();
    idle();
    cycle();

    step_tag = "rsv3";
    rsv_en = 1'b1; rsv_addr = 5'd3; rd_addr1 = 5'd3;
    cycle();
    idle();
    #1;
    chk("rsv3/busy_next", 32'(d1_rd_busy1), 32'd1);
    chk("rsv3/cnt_1", 32'(d1_busy_cnt), 32'd1);
    cycle();
    step_tag = "wr3_clear";
    wr_en1 = 1'b1; wr_addr1 = 5'd3; wr_data1 = 32'h33;
    #1;
    chk("wr3/busy_same_cycle", 32'(d1_rd_busy1), 32'd0);
    chk("wr3/data_bypass", d1_rd_data1, 32'h33);
    cycle();
    idle();
    #1 chk("wr3/cnt_0", 32'(d1_busy_cnt), 32'd0);
    cycle();

    step_tag = "rsv_wr4";
    rsv_en = 1'b1; rsv_addr = 5'd4; wr_en0 = 1'b1; wr_addr0 = 5'd4; wr_data0 = 32'h44;
    rd_addr2 = 5'd4;
    cycle();
    idle();
    #1;
    chk("rsv_wr4/busy", 32'(d1_rd_busy2), 32'd1);
    chk("rsv_wr4/data", d1_rd_data2, 32'h44);
    chk("rsv_wr4/cnt", 32'(d1_busy_cnt), 32'd1);
    cycle();
    step_tag = "rsv0";
    rsv_en = 1'b1; rsv_addr = 5'd0;
    cycle();
    idle();
    #1 chk("rsv0/cnt_unchanged", 32'(d1_busy_cnt), 32'd1);
    cycle();

    step_tag = "rsv_all";
    for (int i = 1; i < 32; i++) begin
      rsv_en = 1'b1; rsv_addr = 5'(i); rd_addr1 = 5'(i);
      cycle();
    end
    idle();
    #1 chk("rsv_all/cnt_31", 32'(d1_busy_cnt), 32'd31);
    cycle();

    step_tag = "mid_reset";
    rst = 1'b1; wr_en0 = 1'b1; wr_addr0 = 5'd6; wr_data0 = 32'hDEAD; rsv_en = 1'b1; rsv_addr = 5'd2;
    cycle();
    idle();
    #1 chk("mid_reset/cnt_0", 32'(d1_busy_cnt), 32'd0);
    step_tag = "reinit_scan";
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i); rd_addr2 = 5'(31 - i);
      cycle();
    end

    step_tag = "random";
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 63) == 0);
      wr_en0   = 1'($urandom_range(0, 1));
      wr_en1   = 1'($urandom_range(0, 1));
      wr_addr0 = 5'($urandom_range(0, 31));
      wr_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr0 : 5'($urandom_range(0, 31));
      wr_data0 = $urandom;
      wr_data1 = $urandom;
      rsv_en   = 1'($urandom_range(0, 1));
      rsv_addr = ($urandom_range(0, 5) == 0) ? wr_addr0 : 5'($urandom_range(0, 31));
      rd_addr1 = ($urandom_range(0, 2) == 0) ? wr_addr0 : 5'($urandom_range(0, 31));
      rd_addr2 = ($urandom_range(0, 2) == 0) ? wr_addr1 : 5'($urandom_range(0, 31));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
